// File: rtl/grf_wb_queue.sv
// grf_wb_queue: write-back queue in front of the general register file write port.
// Buffers pipeline write requests in a small circular buffer and presents the oldest
// entry to the GRF (we3/a3/wd3/pc), one write per cycle, in program order.
// Two combinational bypass lookups return the youngest queued data for a register.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            request handshake; in_pc/in_addr/in_data payload
//   stall                        GRF port busy, head entry is held
//   grf_we/grf_pc/grf_addr/grf_data   GRF write port (head entry, zero when empty)
//   q1_addr/q1_hit/q1_data       bypass lookup 1
//   q2_addr/q2_hit/q2_data       bypass lookup 2
//   count                        number of queued entries
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_addr,
  input  logic [31:0]      in_data,
  input  logic             stall,
  output logic             grf_we,
  output logic [31:0]      grf_pc,
  output logic [4:0]       grf_addr,
  output logic [31:0]      grf_data,
  input  logic [4:0]       q1_addr,
  output logic             q1_hit,
  output logic [31:0]      q1_data,
  input  logic [4:0]       q2_addr,
  output logic             q2_hit,
  output logic [31:0]      q2_data,
  output logic [PTR_W:0]   count
);

  logic [31:0]      pc_q   [DEPTH];
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic accept;
  logic issue;
  logic [PTR_W-1:0] idx;

  assign in_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign grf_we   = (count_q != '0) && !stall;
  assign accept   = in_valid && in_ready;
  assign issue    = grf_we;
  assign count    = count_q;

  assign grf_pc   = (count_q != '0) ? pc_q[rd_ptr_q]   : 32'd0;
  assign grf_addr = (count_q != '0) ? addr_q[rd_ptr_q] : 5'd0;
  assign grf_data = (count_q != '0) ? data_q[rd_ptr_q] : 32'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(issue);
  end

  // Walk entries oldest to youngest starting at the head, so a later match
  // overwrites an earlier one and the youngest matching entry wins.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = 32'd0;
    q2_hit  = 1'b0;
    q2_data = 32'd0;
    idx     = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[idx] && (q1_addr != 5'd0) && (addr_q[idx] == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = data_q[idx];
      end
      if (valid_q[idx] && (q2_addr != 5'd0) && (addr_q[idx] == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Head and tail never alias when both fire: accept requires not-full,
      // issue requires not-empty. Set after clear for robustness anyway.
      if (issue)  valid_q[rd_ptr_q] <= 1'b0;
      if (accept) valid_q[wr_ptr_q] <= 1'b1;
    end
  end

  // Payload needs no reset; valid_q and count_q gate every use of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q[wr_ptr_q]   <= in_pc;
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_grf_wb_queue.sv
module tb_grf_wb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [4:0]  q1_addr;
  logic        q1_hit;
  logic [31:0] q1_data;
  logic [4:0]  q2_addr;
  logic        q2_hit;
  logic [31:0] q2_data;
  logic [2:0]  count;

  grf_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_addr(in_addr), .in_data(in_data),
    .stall(stall),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
    .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  a;
    logic [31:0] d;
    logic        st;
    logic [4:0]  q1a;
    logic [4:0]  q2a;
    logic        chk;
    logic        e_rdy;
    logic        e_we;
    logic [31:0] e_pc;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic [2:0]  e_cnt;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_in(int rst, int iv, int pc, int a, int d, int st, int q1a, int q2a);
    cur.rst = 1'(rst); cur.iv = 1'(iv); cur.pc = 32'(pc); cur.a = 5'(a);
    cur.d = 32'(d); cur.st = 1'(st); cur.q1a = 5'(q1a); cur.q2a = 5'(q2a);
    cur.chk = 1'b1;
    cur.e_h1 = 1'b0; cur.e_d1 = 32'd0; cur.e_h2 = 1'b0; cur.e_d2 = 32'd0;
  endtask

  task automatic set_out(int rdy, int we, int pc, int a, int d, int cnt);
    cur.e_rdy = 1'(rdy); cur.e_we = 1'(we); cur.e_pc = 32'(pc);
    cur.e_a = 5'(a); cur.e_d = 32'(d); cur.e_cnt = 3'(cnt);
  endtask

  task automatic set_byp(int h1, int d1, int h2, int d2);
    cur.e_h1 = 1'(h1); cur.e_d1 = 32'(d1); cur.e_h2 = 1'(h2); cur.e_d2 = 32'(d2);
  endtask

  task automatic push();
    vecs.push_back(cur);
  endtask

  task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  logic [4:0] issued[$];
  logic [4:0] exp_order[5];
  int acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_addr = '0; in_data = '0;
    stall = 1'b0; q1_addr = '0; q2_addr = '0;

    // ---- single request, one-cycle latency
    set_in(1, 0, 0, 0, 0, 0, 0, 0); set_out(0, 0, 0, 0, 0, 0); cur.chk = 1'b0; push();
    set_in(0, 1, 'h3000, 5, 'h1234, 0, 5, 0); set_out(1, 0, 0, 0, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 5, 0); set_out(1, 1, 'h3000, 5, 'h1234, 1);
    set_byp(1, 'h1234, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 5, 0); set_out(1, 0, 0, 0, 0, 0); push();

    // ---- fill under stall, fifth request refused, ordered drain
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 1, k * 16, k, k * 17, 1, 3, 4);
      if (k == 1) set_out(1, 0, 0, 0, 0, 0);
      else        set_out(1, 0, 'h10, 1, 'h11, k - 1);
      if (k == 4) set_byp(1, 'h33, 0, 0);
      push();
    end
    for (int r = 0; r < 2; r++) begin
      set_in(0, 1, 'h50, 5, 'h55, 1, 3, 4); set_out(0, 0, 'h10, 1, 'h11, 4);
      set_byp(1, 'h33, 1, 'h44); push();
    end
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 3, 4);
      set_out((k == 1) ? 0 : 1, 1, k * 16, k, k * 17, 5 - k);
      set_byp((k <= 3) ? 1 : 0, (k <= 3) ? 'h33 : 0, 1, 'h44); push();
    end
    set_in(0, 0, 0, 0, 0, 0, 3, 4); set_out(1, 0, 0, 0, 0, 0); push();

    // ---- same-register writes: bypass youngest, commit oldest first; addr 0 never hits
    set_in(0, 1, 'h70, 7, 'hA, 1, 7, 0); set_out(1, 0, 0, 0, 0, 0); push();
    set_in(0, 1, 'h71, 7, 'hB, 1, 7, 0); set_out(1, 0, 'h70, 7, 'hA, 1);
    set_byp(1, 'hA, 0, 0); push();
    set_in(0, 1, 'h72, 0, 'hCC, 1, 7, 0); set_out(1, 0, 'h70, 7, 'hA, 2);
    set_byp(1, 'hB, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 1, 7, 0); set_out(1, 0, 'h70, 7, 'hA, 3);
    set_byp(1, 'hB, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 7, 0); set_out(1, 1, 'h70, 7, 'hA, 3);
    set_byp(1, 'hB, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 7, 0); set_out(1, 1, 'h71, 7, 'hB, 2);
    set_byp(1, 'hB, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 7, 0); set_out(1, 1, 'h72, 0, 'hCC, 1); push();
    set_in(0, 0, 0, 0, 0, 0, 7, 0); set_out(1, 0, 0, 0, 0, 0); push();

    // ---- streaming: enqueue every cycle, pointers wrap, incoming not searched
    for (int k = 0; k < 10; k++) begin
      set_in(0, 1, 'h200 + k, 8 + k, 'h100 + k, 0, 8 + k, 0);
      if (k == 0) set_out(1, 0, 0, 0, 0, 0);
      else        set_out(1, 1, 'h200 + k - 1, 7 + k, 'h100 + k - 1, 1);
      push();
    end
    set_in(0, 0, 0, 0, 0, 0, 17, 0); set_out(1, 1, 'h209, 17, 'h109, 1);
    set_byp(1, 'h109, 0, 0); push();
    set_in(0, 0, 0, 0, 0, 0, 17, 0); set_out(1, 0, 0, 0, 0, 0); push();

    // ---- reset mid-operation drops pending entries and the concurrent request
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 'h414 + k, 20 + k, 'h2014 + k, 1, 21, 0);
      if (k == 0) set_out(1, 0, 0, 0, 0, 0);
      else        set_out(1, 0, 'h414, 20, 'h2014, k);
      if (k == 2) set_byp(1, 'h2015, 0, 0);
      push();
    end
    set_in(1, 1, 'h417, 23, 'h2017, 1, 21, 23); set_out(1, 0, 'h414, 20, 'h2014, 3);
    set_byp(1, 'h2015, 0, 0); push();
    for (int r = 0; r < 2; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 21, 23); set_out(1, 0, 0, 0, 0, 0); push();
    end

    // ---- full queue with stall toggling
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 'h600 + k, 24 + k, 'h60 + k, 1, 0, 0);
      if (k == 0) set_out(1, 0, 0, 0, 0, 0);
      else        set_out(1, 0, 'h600, 24, 'h60, k);
      push();
    end
    for (int j = 0; j < 9; j++) begin
      int h, cnt, st;
      h = j / 2; cnt = 4 - h; st = ((j % 2) == 0) ? 1 : 0;
      set_in(0, 0, 0, 0, 0, st, 0, 0);
      if (cnt > 0) set_out((cnt != 4) ? 1 : 0, (st == 0) ? 1 : 0, 'h600 + h, 24 + h, 'h60 + h, cnt);
      else         set_out(1, 0, 0, 0, 0, 0);
      push();
    end

    // ---- apply the table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_pc = vecs[i].pc;
      in_addr = vecs[i].a; in_data = vecs[i].d; stall = vecs[i].st;
      q1_addr = vecs[i].q1a; q2_addr = vecs[i].q2a;
      #1;
      if (vecs[i].chk) begin
        check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
        check("grf_we",   i, 32'(grf_we),   32'(vecs[i].e_we));
        check("grf_pc",   i, grf_pc,        vecs[i].e_pc);
        check("grf_addr", i, 32'(grf_addr), 32'(vecs[i].e_a));
        check("grf_data", i, grf_data,      vecs[i].e_d);
        check("count",    i, 32'(count),    32'(vecs[i].e_cnt));
        check("q1_hit",   i, 32'(q1_hit),   32'(vecs[i].e_h1));
        check("q1_data",  i, q1_data,       vecs[i].e_d1);
        check("q2_hit",   i, 32'(q2_hit),   32'(vecs[i].e_h2));
        check("q2_data",  i, q2_data,       vecs[i].e_d2);
      end
    end

    // ---- producer holds a request against a full queue; accepted once a slot frees
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b1; in_pc = 32'(k); in_addr = 5'(k + 1);
      in_data = 32'(k); stall = 1'b1; q1_addr = '0; q2_addr = '0;
    end
    @(negedge clk);
    in_addr = 5'd30; in_data = 32'h300; in_pc = 32'h3300; stall = 1'b0;
    acc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (grf_we) issued.push_back(grf_addr);
      if (in_valid && in_ready) acc = c;
      @(negedge clk);
      if (acc >= 0) in_valid = 1'b0;
    end
    exp_order[0] = 5'd1; exp_order[1] = 5'd2; exp_order[2] = 5'd3;
    exp_order[3] = 5'd4; exp_order[4] = 5'd30;
    check("held_accept_cycle", -1, 32'(acc), 32'd1);
    check("held_issue_count", -1, 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < issued.size()) check("held_issue_order", i, 32'(issued[i]), 32'(exp_order[i]));
      else check("held_issue_missing", i, 32'hFFFF_FFFF, 32'(exp_order[i]));
    end
    #1;
    check("held_final_count", -1, 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
